// File: rtl/inst_sraml2axi_if.sv
// Bus interfaces for the instruction-side SRAM-like to AXI read bridge.
//
// inst_sram_if   : SRAM-like fetch port.
//                  master = the upstream requester; slave = the bridge.
//                  Request : inst_req, inst_wr, inst_size, inst_addr, inst_wdata
//                  Response: inst_addr_ok, inst_data_ok, inst_rdata, inst_bus_err
// inst_axi_rd_if : AXI4 read-address and read-data channels.
//                  master = the bridge; slave = the memory system.
//                  AR: arid, araddr, arlen, arsize, arburst, arlock, arcache,
//                      arprot, arvalid / arready
//                  R : rid, rdata, rresp, rlast, rvalid / rready

interface inst_sram_if;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        inst_bus_err;

  modport master (
    output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata, inst_bus_err
  );

  modport slave (
    input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    output inst_addr_ok, inst_data_ok, inst_rdata, inst_bus_err
  );
endinterface

interface inst_axi_rd_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/inst_sraml2axi.sv
// Instruction-side bridge: SRAM-like fetch requests to single-beat AXI4 reads.
// One transaction is outstanding at a time; a non-OKAY rresp is reported to
// the core as a one-cycle inst_bus_err pulse alongside inst_data_ok.
//
// Ports
//   clk    : clock, all state on rising edge
//   resetn : asynchronous active-low reset
//   sram   : SRAM-like fetch port (slave side); inst_wr / inst_wdata ignored
//   axi    : AXI4 AR/R channels (master side); rid ignored
// Parameter
//   ARID_VAL : constant driven on arid

module inst_sraml2axi #(
  parameter logic [3:0] ARID_VAL = 4'd0
) (
  input  logic           clk,
  input  logic           resetn,
  inst_sram_if.slave     sram,
  inst_axi_rd_if.master  axi
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_addr_q;
  logic [1:0]  r_size_q;
  logic        w_accept;
  logic        w_unused;

  // The bridge only reads; these inputs are deliberately left unconnected.
  assign w_unused = ^{sram.inst_wr, sram.inst_wdata, axi.rid};

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the address/size holders carry an explicit reset so araddr/arsize
  // never show X after reset, even though they are only consumed in AR.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr_q <= '0;
      r_size_q <= '0;
    end else if (w_accept) begin
      r_addr_q <= sram.inst_addr;
      r_size_q <= sram.inst_size;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt       = r_state;
    w_accept          = 1'b0;
    sram.inst_addr_ok = 1'b0;
    sram.inst_data_ok = 1'b0;
    sram.inst_rdata   = '0;
    sram.inst_bus_err = 1'b0;
    axi.arvalid       = 1'b0;
    axi.rready        = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        sram.inst_addr_ok = sram.inst_req;
        w_accept          = sram.inst_req;
        if (sram.inst_req) w_state_nxt = S_AR;
      end
      S_AR: begin
        // arvalid is a pure state decode, so it is glitch-free and drops
        // the instant resetn forces the state register back to IDLE.
        axi.arvalid = 1'b1;
        if (axi.arready) w_state_nxt = S_R;
      end
      S_R: begin
        axi.rready = 1'b1;
        // A beat without rlast is accepted and dropped; with arlen=0 the
        // only beat is also the last one.
        if (axi.rvalid && axi.rlast) begin
          sram.inst_data_ok = 1'b1;
          sram.inst_rdata   = axi.rdata;
          sram.inst_bus_err = (axi.rresp != 2'b00);
          w_state_nxt       = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request fields are held in flops, so they stay stable while arvalid is up.
  assign axi.araddr  = r_addr_q;
  assign axi.arsize  = {1'b0, r_size_q};
  assign axi.arid    = ARID_VAL;
  assign axi.arlen   = 8'd0;
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'b0000;
  assign axi.arprot  = 3'b000;

endmodule

// File: tb/tb_inst_sraml2axi.sv
// Self-checking bench for inst_sraml2axi. Stimulus queues each fetch's
// expected AR fields and read response; a negedge monitor compares whatever
// the DUT presents against those queues and against transaction counts.

module tb_inst_sraml2axi;

  localparam logic [3:0] ARID = 4'd5;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
  } exp_ar_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_r_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    int          ar_w;
    int          r_w;
  } slv_cfg_t;

  logic clk;
  logic resetn;
  int   cyc;
  int   n_cmp;
  int   n_err;

  exp_ar_t  exp_ar_q[$];
  exp_r_t   exp_r_q[$];
  slv_cfg_t cfg_q[$];
  int       data_cyc_q[$];
  int       acc_cyc;
  int       ar_first_cyc;

  inst_sram_if   sram ();
  inst_axi_rd_if axi  ();

  inst_sraml2axi #(.ARID_VAL(ARID)) dut (
    .clk    (clk),
    .resetn (resetn),
    .sram   (sram.slave),
    .axi    (axi.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- AXI slave model ----------------
  initial begin : slave
    slv_cfg_t cur;
    bit       have_cfg;
    have_cfg    = 0;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rlast   = 1'b0;
    axi.rdata   = '0;
    axi.rresp   = '0;
    axi.rid     = '0;
    forever begin
      @(posedge clk); #1;
      axi.arready = 1'b0;
      axi.rvalid  = 1'b0;
      axi.rlast   = 1'b0;
      axi.rdata   = '0;
      axi.rresp   = '0;
      if (!resetn) begin
        have_cfg = 0;
        continue;
      end
      if (axi.arvalid) begin
        if (!have_cfg && cfg_q.size() > 0) begin
          cur      = cfg_q.pop_front();
          have_cfg = 1;
        end
        if (have_cfg) begin
          if (cur.ar_w > 0) cur.ar_w--;
          else axi.arready = 1'b1;
        end
      end else if (axi.rready && have_cfg) begin
        if (cur.r_w > 0) cur.r_w--;
        else begin
          axi.rvalid = 1'b1;
          axi.rlast  = 1'b1;
          axi.rdata  = cur.data;
          axi.rresp  = cur.resp;
          axi.rid    = 4'($urandom);
          have_cfg   = 0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    int   n_acc, n_ar, n_dat;
    logic prev_arvalid;
    exp_ar_t ea;
    exp_r_t  er;
    n_acc = 0; n_ar = 0; n_dat = 0; prev_arvalid = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        check("rst_arvalid", axi.arvalid, 1'b0);
        check("rst_rready", axi.rready, 1'b0);
        check("rst_addr_ok", sram.inst_addr_ok, 1'b0);
        check("rst_data_ok", sram.inst_data_ok, 1'b0);
        check("rst_bus_err", sram.inst_bus_err, 1'b0);
        check("rst_rdata", sram.inst_rdata, 32'h0);
        n_acc = 0; n_ar = 0; n_dat = 0; prev_arvalid = 1'b0;
        continue;
      end
      // A fetch is in flight from acceptance until its data returns.
      check("addr_ok", sram.inst_addr_ok, sram.inst_req && (n_acc == n_dat));
      check("arvalid", axi.arvalid, n_acc > n_ar);
      check("rready", axi.rready, n_ar > n_dat);
      check("data_ok", sram.inst_data_ok, (n_ar > n_dat) && axi.rvalid && axi.rlast);

      if (axi.arvalid) begin
        if (!prev_arvalid) ar_first_cyc = cyc;
        if (exp_ar_q.size() == 0) begin
          check("ar_unexpected", 1'b1, 1'b0);
        end else begin
          ea = exp_ar_q[0];
          check("araddr", axi.araddr, ea.addr);
          check("arsize", axi.arsize, ea.size);
          check("ar_const", {axi.arid, axi.arlen, axi.arburst, axi.arlock, axi.arcache, axi.arprot},
                {ARID, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
          if (axi.arready) begin
            void'(exp_ar_q.pop_front());
            n_ar++;
          end
        end
      end
      prev_arvalid = axi.arvalid;

      if (sram.inst_data_ok) begin
        if (exp_r_q.size() == 0) begin
          check("data_unexpected", 1'b1, 1'b0);
        end else begin
          er = exp_r_q.pop_front();
          check("rdata", sram.inst_rdata, er.data);
          check("bus_err", sram.inst_bus_err, er.err);
        end
        data_cyc_q.push_back(cyc);
        n_dat++;
      end else begin
        check("idle_rdata", sram.inst_rdata, 32'h0);
        check("idle_bus_err", sram.inst_bus_err, 1'b0);
      end

      if (sram.inst_addr_ok) begin
        acc_cyc = cyc;
        n_acc++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called and returning at posedge+1.
  task automatic fetch(input logic [31:0] a, input logic [1:0] sz, input int arw,
                       input int rw, input logic [31:0] d, input logic [1:0] resp);
    slv_cfg_t c;
    exp_ar_t  ea;
    exp_r_t   er;
    bit       got;
    c.data = d; c.resp = resp; c.ar_w = arw; c.r_w = rw;
    ea.addr = a; ea.size = {1'b0, sz};
    er.data = d; er.err = (resp != 2'b00);
    cfg_q.push_back(c);
    exp_ar_q.push_back(ea);
    exp_r_q.push_back(er);
    sram.inst_req   = 1'b1;
    sram.inst_addr  = a;
    sram.inst_size  = sz;
    sram.inst_wr    = 1'($urandom);
    sram.inst_wdata = $urandom;
    got = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sram.inst_addr_ok) begin
        got = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!got) check("accept_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    sram.inst_req = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (exp_r_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) check("idle_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main stimulus ----------------
  initial begin : stim
    int base_n;
    bit seen;
    n_cmp = 0; n_err = 0; cyc = 0;
    acc_cyc = 0; ar_first_cyc = 0;
    resetn          = 1'b0;
    sram.inst_req   = 1'b0;
    sram.inst_wr    = 1'b0;
    sram.inst_size  = 2'b10;
    sram.inst_addr  = '0;
    sram.inst_wdata = '0;
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;
    @(posedge clk); #1;

    // Basic read with minimum latency.
    fetch(32'hBFC0_0000, 2'b10, 0, 0, 32'h3C1D_BFC0, 2'b00);
    wait_idle();
    check("lat_arvalid", ar_first_cyc - acc_cyc, 1);
    check("lat_data_ok", data_cyc_q[data_cyc_q.size()-1] - acc_cyc, 2);

    // AR back-pressure; the next request is already waiting with req high.
    fetch(32'h0000_1000, 2'b10, 5, 0, 32'h1111_2222, 2'b00);
    fetch(32'h0000_1004, 2'b10, 0, 0, 32'h3333_4444, 2'b00);
    wait_idle();

    // R stall of 7 cycles: exactly one data_ok.
    base_n = data_cyc_q.size();
    fetch(32'h0000_2000, 2'b10, 0, 7, 32'hDEAD_BEEF, 2'b00);
    wait_idle();
    check("rstall_pulses", data_cyc_q.size() - base_n, 1);

    // Back-to-back with zero-wait slave: pulses 3 cycles apart.
    data_cyc_q.delete();
    fetch(32'hBFC0_0000, 2'b10, 0, 0, 32'hA000_0001, 2'b00);
    fetch(32'hBFC0_0004, 2'b10, 0, 0, 32'hA000_0002, 2'b00);
    fetch(32'hBFC0_0008, 2'b10, 0, 0, 32'hA000_0003, 2'b00);
    wait_idle();
    check("b2b_count", data_cyc_q.size(), 3);
    if (data_cyc_q.size() == 3) begin
      check("b2b_gap1", data_cyc_q[1] - data_cyc_q[0], 3);
      check("b2b_gap2", data_cyc_q[2] - data_cyc_q[1], 3);
    end

    // Bus error followed by a normal fetch.
    fetch(32'h0000_3000, 2'b10, 1, 1, 32'h0BAD_0BAD, 2'b10);
    fetch(32'h0000_3004, 2'b10, 0, 0, 32'h600D_600D, 2'b00);
    wait_idle();

    // Asynchronous reset while waiting in R.
    fetch(32'h0000_4000, 2'b10, 0, 20, 32'h5555_AAAA, 2'b00);
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (axi.rready) begin
        seen = 1;
        break;
      end
    end
    check("reach_r", seen, 1'b1);
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    check("async_rready", axi.rready, 1'b0);
    check("async_arvalid", axi.arvalid, 1'b0);
    repeat (2) @(posedge clk);
    exp_ar_q.delete();
    exp_r_q.delete();
    cfg_q.delete();
    #2 resetn = 1'b1;
    @(posedge clk); #1;
    fetch(32'h0000_5000, 2'b10, 0, 0, 32'h7777_8888, 2'b00);
    wait_idle();

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      logic [1:0] rsp;
      rsp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      fetch({$urandom} & 32'hFFFF_FFFC, 2'($urandom_range(0, 2)),
            $urandom_range(0, 4), $urandom_range(0, 4), $urandom, rsp);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    wait_idle();
    check("ar_queue_empty", exp_ar_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
